// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: state codes, error codes and
// frame-field byte counts.
package program_loader_pkg;

  // 3-bit state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_HOLD   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LEN_HI = ST_LEN_HI,
    LEN_LO = ST_LEN_LO,
    DATA   = ST_DATA,
    CHECK  = ST_CHECK,
    HOLD   = ST_HOLD,
    DONE   = ST_DONE,
    ERR    = ST_ERR
  } state_t;

  // Error codes reported on the error output
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_CSUM    = 2'b11;

  // Frame-field sizes in bytes
  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CSUM_BYTES = 1;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The loader uses the master view; the stream source / memory side uses slave.
interface program_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs payload bytes MSB-first into 32-bit words and keeps a running XOR
// checksum over every accepted byte.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o,
  output logic        word_ready_o
);

  logic [31:0] shift_q;
  logic [1:0]  idx_q;
  logic [7:0]  csum_q;

  // The byte being accepted now completes a word
  assign word_ready_o = accept_i && (idx_q == 2'(WORD_BYTES - 1));
  assign word_o       = shift_q;
  assign csum_o       = csum_q;

  // Shift register, byte index and checksum; clear wins over accept
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      shift_q <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
    end else if (accept_i) begin
      shift_q <= {shift_q[23:0], byte_i};
      idx_q   <= idx_q + 2'd1;
      csum_q  <= csum_q ^ byte_i;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a framed program image from a byte stream into instruction memory
// while holding the CPU stalled and in reset; releases it after a good load.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = 1000000,
  parameter int RST_HOLD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  program_loader_if.master  bus,
  output logic              cpu_stall,
  output logic              cpu_reset,
  output logic              busy,
  output logic              load_done,
  output logic [1:0]        error,
  output logic [ADDR_W:0]   word_count
);

  localparam int          GAP_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int          HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  state_t              state_q, state_d;
  logic [1:0]          error_q, error_d;
  logic [GAP_W-1:0]    gap_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [7:0]          len_hi_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     wc_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic                held_q;
  logic                done_q;

  logic        in_frame, can_start, byte_ok, timed_out, len_bad, n_zero, last_word;
  logic        word_ready;
  logic [15:0] n_frame;
  logic [31:0] word;
  logic [7:0]  csum;

  assign in_frame  = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                     (state_q == DATA)   || (state_q == CHECK);
  assign can_start = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
  assign byte_ok   = bus.rx_valid && in_frame;
  assign timed_out = in_frame && !byte_ok && (gap_q == GAP_W'(TIMEOUT - 1));
  assign n_frame   = {len_hi_q, bus.rx_data};
  assign len_bad   = 32'(n_frame) > MAX_WORDS;
  assign n_zero    = (n_frame == 16'd0);
  assign last_word = ((wc_q + 1'b1) == len_q);

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (start && can_start),
    .accept_i     (byte_ok && (state_q == DATA)),
    .byte_i       (bus.rx_data),
    .word_o       (word),
    .csum_o       (csum),
    .word_ready_o (word_ready)
  );

  // Next-state and error-code selection; a timeout overrides everything
  always_comb begin
    state_d = state_q;
    error_d = error_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = LEN_HI;
        error_d = ERR_NONE;
      end
      LEN_HI: if (byte_ok) state_d = LEN_LO;
      LEN_LO: if (byte_ok) begin
        if (len_bad) begin
          state_d = ERR;
          error_d = ERR_LEN;
        end else if (n_zero) begin
          state_d = CHECK;
        end else begin
          state_d = DATA;
        end
      end
      DATA:   if (word_ready && last_word) state_d = CHECK;
      CHECK:  if (byte_ok) begin
        if (bus.rx_data == csum) begin
          state_d = HOLD;
        end else begin
          state_d = ERR;
          error_d = ERR_CSUM;
        end
      end
      HOLD:   if (hold_q == HOLD_W'(RST_HOLD - 1)) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (timed_out) begin
      state_d = ERR;
      error_d = ERR_TIMEOUT;
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      error_q     <= ERR_NONE;
      gap_q       <= '0;
      hold_q      <= '0;
      len_hi_q    <= '0;
      len_q       <= '0;
      wc_q        <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= ADDR_W'(BASE_ADDR);
      held_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      error_q   <= error_d;
      gap_q     <= (byte_ok || !in_frame) ? '0 : gap_q + 1'b1;
      hold_q    <= (state_q == HOLD) ? hold_q + 1'b1 : '0;
      imem_we_q <= word_ready;
      if (state_q == LEN_HI && byte_ok) len_hi_q <= bus.rx_data;
      if (state_q == LEN_LO && byte_ok) len_q <= n_frame[ADDR_W:0];
      if (word_ready) begin
        imem_addr_q <= ADDR_W'(BASE_ADDR) + wc_q[ADDR_W-1:0];
        wc_q        <= wc_q + 1'b1;
      end
      if (start && can_start) wc_q <= '0;
      // CPU is held (and the loader busy) everywhere except IDLE and DONE
      held_q <= (state_d != IDLE) && (state_d != DONE);
      done_q <= (state_d == DONE);
    end
  end

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = word;
  assign cpu_stall      = held_q;
  assign cpu_reset      = held_q;
  assign busy           = held_q;
  assign load_done      = done_q;
  assign error          = error_q;
  assign word_count     = wc_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized frame-level bench for program_loader with a behavioural model
// of the expected memory writes, error code and final status.
module tb_program_loader;

  localparam int ADDR_W = 10;
  localparam int BASE   = 1020;
  localparam int TMO    = 50;
  localparam int HOLD   = 4;

  logic              clk = 1'b0;
  logic              reset, start;
  logic              cpu_stall, cpu_reset, busy, load_done;
  logic [1:0]        error;
  logic [ADDR_W:0]   word_count;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT(TMO), .RST_HOLD(HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .cpu_stall  (cpu_stall),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .load_done  (load_done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write strobe seen on the memory bus: {pad, addr, data}
  logic [63:0] wr_q[$];
  always @(negedge clk)
    if (bus.imem_we === 1'b1) wr_q.push_back({22'd0, bus.imem_addr, bus.imem_wdata});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    repeat ($urandom_range(0, max_gap)) tick();
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends one frame of n words and checks the outcome against the model:
  // n > 2^ADDR_W -> length error after the header, bad -> checksum error,
  // otherwise word i lands at (BASE+i) mod 2^ADDR_W and the CPU is released.
  task automatic run_frame(input int n, input bit bad, input int max_gap,
                           input bit mid_start, input string name);
    logic [7:0]  sum;
    logic [31:0] w;
    logic [63:0] exp_q[$];
    logic [1:0]  exp_err;
    int          exp_wc, hold_seen, k;
    sum = 8'h00;
    wr_q.delete();
    pulse_start();
    check({name, " error cleared"}, 64'(error), 64'(2'b00));
    check({name, " busy"}, 64'(busy), 64'd1);
    send_byte(8'((n >> 8) & 255), max_gap);
    send_byte(8'(n & 255), max_gap);
    if (n > (1 << ADDR_W)) begin
      exp_err = 2'b10;
      exp_wc  = 0;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        exp_q.push_back({22'd0, 10'((BASE + i) % (1 << ADDR_W)), w});
        for (int b = 3; b >= 0; b--) begin
          send_byte(w[8*b +: 8], max_gap);
          sum = sum ^ w[8*b +: 8];
          if (mid_start && i == 0 && b == 3) pulse_start();
        end
      end
      if (bad) send_byte(sum ^ 8'($urandom_range(1, 255)), max_gap);
      else     send_byte(sum, max_gap);
      exp_err = bad ? 2'b11 : 2'b00;
      exp_wc  = n;
    end
    hold_seen = 0;
    k = 0;
    while (load_done !== 1'b1 && error === 2'b00 && k < 40) begin
      if (cpu_reset === 1'b1) hold_seen++;
      tick();
      k++;
    end
    if (exp_err == 2'b00) begin
      check({name, " hold cycles"}, 64'(hold_seen), 64'(HOLD));
      check({name, " load_done"}, 64'(load_done), 64'd1);
      check({name, " cpu_reset"}, 64'(cpu_reset), 64'd0);
      check({name, " cpu_stall"}, 64'(cpu_stall), 64'd0);
      check({name, " busy"}, 64'(busy), 64'd0);
    end else begin
      check({name, " load_done"}, 64'(load_done), 64'd0);
      check({name, " cpu_reset held"}, 64'(cpu_reset), 64'd1);
      check({name, " cpu_stall held"}, 64'(cpu_stall), 64'd1);
    end
    check({name, " error"}, 64'(error), 64'(exp_err));
    check({name, " word_count"}, 64'(word_count), 64'(exp_wc));
    check({name, " write count"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s write %0d", name, i), wr_q[i], exp_q[i]);
    $display("frame %s: n=%0d error=%0d word_count=%0d writes=%0d", name, n, error, word_count, wr_q.size());
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) tick();
    check("reset imem_we", 64'(bus.imem_we), 64'd0);
    check("reset imem_addr", 64'(bus.imem_addr), 64'(BASE));
    check("reset imem_wdata", 64'(bus.imem_wdata), 64'd0);
    check("reset cpu_stall", 64'(cpu_stall), 64'd0);
    check("reset cpu_reset", 64'(cpu_reset), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset load_done", 64'(load_done), 64'd0);
    check("reset error", 64'(error), 64'd0);
    check("reset word_count", 64'(word_count), 64'd0);
    reset = 1'b0;
    tick();

    // Bytes in IDLE without start are ignored
    wr_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    tick();
    check("idle rx busy", 64'(busy), 64'd0);
    check("idle rx writes", 64'(wr_q.size()), 64'd0);
    $display("idle rx: busy=%0d writes=%0d", busy, wr_q.size());

    run_frame(2, 1'b0, 0, 1'b0, "nominal");
    run_frame(2, 1'b1, 0, 1'b0, "bad_csum");
    run_frame(2, 1'b0, 1, 1'b0, "recover");
    run_frame(1025, 1'b0, 0, 1'b0, "len_over");
    run_frame(0, 1'b0, 0, 1'b0, "len_zero");
    run_frame(1024, 1'b0, 0, 1'b0, "len_max");
    run_frame(2, 1'b0, 1, 1'b1, "mid_start");

    // Timeout: two data bytes then silence
    wr_q.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h24, 0);
    send_byte(8'h08, 0);
    repeat (TMO - 1) tick();
    check("timeout early error", 64'(error), 64'd0);
    check("timeout early busy", 64'(busy), 64'd1);
    tick();
    check("timeout error", 64'(error), 64'(2'b01));
    check("timeout cpu_stall", 64'(cpu_stall), 64'd1);
    check("timeout writes", 64'(wr_q.size()), 64'd0);
    $display("timeout: error=%0d writes=%0d", error, wr_q.size());

    for (int r = 0; r < 10; r++)
      run_frame($urandom_range(0, 8), ($urandom_range(0, 3) == 0), 3, 1'b0,
                $sformatf("rand%0d", r));

    // Bytes in DONE without start are ignored
    run_frame(1, 1'b0, 0, 1'b0, "pre_spurious");
    wr_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    send_byte(8'hAA, 0);
    tick();
    check("done rx load_done", 64'(load_done), 64'd1);
    check("done rx word_count", 64'(word_count), 64'd1);
    check("done rx writes", 64'(wr_q.size()), 64'd0);
    $display("done rx: load_done=%0d writes=%0d", load_done, wr_q.size());

    // Reset in the middle of DATA
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 0);
    reset = 1'b1;
    tick();
    check("midreset imem_we", 64'(bus.imem_we), 64'd0);
    check("midreset imem_addr", 64'(bus.imem_addr), 64'(BASE));
    check("midreset imem_wdata", 64'(bus.imem_wdata), 64'd0);
    check("midreset cpu_stall", 64'(cpu_stall), 64'd0);
    check("midreset cpu_reset", 64'(cpu_reset), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset error", 64'(error), 64'd0);
    check("midreset word_count", 64'(word_count), 64'd0);
    reset = 1'b0;
    wr_q.delete();
    send_byte(8'h07, 0);
    send_byte(8'h08, 0);
    repeat (3) tick();
    check("midreset writes after", 64'(wr_q.size()), 64'd0);
    check("midreset stays idle", 64'(busy), 64'd0);
    $display("midreset: busy=%0d writes=%0d", busy, wr_q.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
